// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: opcodes, register numbers, field positions and ExcCodes.
// Also used by the CP0 forwarding unit.
package cp0_pkg;

    localparam logic [2:0] CP0OP_MFC0 = 3'b001;
    localparam logic [2:0] CP0OP_MTC0 = 3'b010;
    localparam logic [2:0] CP0OP_ERET = 3'b100;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IPSW_HI = 9;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    // Only sel 0 is implemented for every register.
    function automatic logic cp0_hit(input logic [4:0] cs, input logic [2:0] sel,
                                     input logic [4:0] regnum);
        return (sel == 3'd0) && (cs == regnum);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI latches on a nonzero match
// and is cleared by any write to Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic        w_match;

    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            // A software load restarts the half-rate phase as well as the value.
            if (i_count_we) begin
                r_count <= i_wr_data;
                r_tick  <= 1'b0;
            end else begin
                if (r_tick)
                    r_count <= r_count + 32'd1;
                r_tick <= ~r_tick;
            end

            if (i_compare_we)
                r_compare <= i_wr_data;

            if (i_compare_we)
                r_ti <= 1'b0;
            else if (w_match)
                r_ti <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: mtc0 writes from WB, mfc0/eret reads to ID, exception state
// capture, and the interrupt request.
module cp0_regs
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_cp0op,
    input  logic [4:0]  id_cs,
    input  logic [2:0]  id_sel,
    input  logic [2:0]  wr_cp0op,
    input  logic [4:0]  wr_cs,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        exc_badv_we,
    input  logic        eret_commit,
    input  logic [5:0]  hw_int,
    output logic [31:0] rd_data,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic        int_req
);

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_iphw;
    logic [1:0]  r_cause_ipsw;
    logic [4:0]  r_cause_exc;

    logic        w_mtc0;
    logic        w_we_count;
    logic        w_we_compare;
    logic        w_we_status;
    logic        w_we_cause;
    logic        w_we_epc;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [7:0]  w_ip;
    logic [31:0] w_reg_val;

    assign w_mtc0       = (wr_cp0op == CP0OP_MTC0);
    assign w_we_count   = w_mtc0 && cp0_hit(wr_cs, wr_sel, CP0_COUNT);
    assign w_we_compare = w_mtc0 && cp0_hit(wr_cs, wr_sel, CP0_COMPARE);
    assign w_we_status  = w_mtc0 && cp0_hit(wr_cs, wr_sel, CP0_STATUS);
    assign w_we_cause   = w_mtc0 && cp0_hit(wr_cs, wr_sel, CP0_CAUSE);
    assign w_we_epc     = w_mtc0 && cp0_hit(wr_cs, wr_sel, CP0_EPC);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_we_count),
        .i_compare_we (w_we_compare),
        .i_wr_data    (wr_data),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Later assignments win: software write first, then exception/eret state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr   <= 32'd0;
            r_epc        <= 32'd0;
            r_status_im  <= 8'd0;
            r_status_exl <= 1'b1;
            r_status_ie  <= 1'b0;
            r_cause_bd   <= 1'b0;
            r_cause_iphw <= 6'd0;
            r_cause_ipsw <= 2'd0;
            r_cause_exc  <= 5'd0;
        end else begin
            r_cause_iphw <= hw_int;

            if (w_we_status) begin
                r_status_im  <= wr_data[STATUS_IM_HI:STATUS_IM_LO];
                r_status_exl <= wr_data[STATUS_EXL];
                r_status_ie  <= wr_data[STATUS_IE];
            end
            if (w_we_cause)
                r_cause_ipsw <= wr_data[CAUSE_IPSW_HI:CAUSE_IP_LO];
            if (w_we_epc)
                r_epc <= wr_data;

            if (exc_valid) begin
                r_status_exl <= 1'b1;
                r_cause_exc  <= exc_code;
                r_cause_bd   <= exc_bd;
                r_epc        <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                if (exc_badv_we)
                    r_badvaddr <= exc_badvaddr;
            end else if (eret_commit) begin
                r_status_exl <= 1'b0;
            end
        end
    end

    assign w_ip = {r_cause_iphw[5] | w_ti, r_cause_iphw[4:0], r_cause_ipsw};

    assign status_out = {16'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign cause_out  = {r_cause_bd, w_ti, 14'd0, w_ip, 1'b0, r_cause_exc, 2'b00};
    assign epc_out    = r_epc;
    assign int_req    = r_status_ie & ~r_status_exl & (|(w_ip & r_status_im));

    always_comb begin
        w_reg_val = 32'd0;
        if (id_sel == 3'd0) begin
            case (id_cs)
                CP0_BADVADDR: w_reg_val = r_badvaddr;
                CP0_COUNT:    w_reg_val = w_count;
                CP0_COMPARE:  w_reg_val = w_compare;
                CP0_STATUS:   w_reg_val = status_out;
                CP0_CAUSE:    w_reg_val = cause_out;
                CP0_EPC:      w_reg_val = r_epc;
                default:      w_reg_val = 32'd0;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (id_cp0op == CP0OP_MFC0)
            rd_data = w_reg_val;
        else if (id_cp0op == CP0OP_ERET)
            rd_data = r_epc;
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed-vector bench for cp0_regs with hand-computed expected values.
module tb_cp0_regs;
    import cp0_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  id_cp0op;
    logic [4:0]  id_cs;
    logic [2:0]  id_sel;
    logic [2:0]  wr_cp0op;
    logic [4:0]  wr_cs;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        exc_badv_we;
    logic        eret_commit;
    logic [5:0]  hw_int;
    logic [31:0] rd_data;
    logic [31:0] epc_out;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic        int_req;

    int n_vec;
    int n_miss;

    cp0_regs dut (
        .clk          (clk),
        .rst          (rst),
        .id_cp0op     (id_cp0op),
        .id_cs        (id_cs),
        .id_sel       (id_sel),
        .wr_cp0op     (wr_cp0op),
        .wr_cs        (wr_cs),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_bd       (exc_bd),
        .exc_badvaddr (exc_badvaddr),
        .exc_badv_we  (exc_badv_we),
        .eret_commit  (eret_commit),
        .hw_int       (hw_int),
        .rd_data      (rd_data),
        .epc_out      (epc_out),
        .status_out   (status_out),
        .cause_out    (cause_out),
        .int_req      (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] cs, input logic [2:0] sel, input logic [31:0] data);
        wr_cp0op = CP0OP_MTC0;
        wr_cs    = cs;
        wr_sel   = sel;
        wr_data  = data;
        step();
        wr_cp0op = 3'b000;
    endtask

    task automatic mfc0_chk(input string tag, input logic [4:0] cs, input logic [2:0] sel,
                            input logic [31:0] exp);
        id_cp0op = CP0OP_MFC0;
        id_cs    = cs;
        id_sel   = sel;
        #1;
        check_vec(tag, rd_data, exp);
        id_cp0op = 3'b000;
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        id_cp0op = 3'b000; id_cs = 5'd0; id_sel = 3'd0;
        wr_cp0op = 3'b000; wr_cs = 5'd0; wr_sel = 3'd0; wr_data = 32'd0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
        exc_badvaddr = 32'd0; exc_badv_we = 1'b0; eret_commit = 1'b0; hw_int = 6'd0;
        // reset wins over a same-cycle write
        wr_cp0op = CP0OP_MTC0; wr_cs = CP0_EPC; wr_data = 32'hFFFF_0000;
        step();
        step();
        wr_cp0op = 3'b000;
        rst = 1'b0;

        check_vec("rst_status", status_out, 32'h0000_0002);
        check_vec("rst_epc", epc_out, 32'h0);
        check_vec("rst_cause", cause_out, 32'h0);
        check_vec("rst_intreq", {31'd0, int_req}, 32'd0);
        check_vec("rst_rd_idle", rd_data, 32'h0);
        mfc0_chk("rst_mfc0_status", CP0_STATUS, 3'd0, 32'h0000_0002);
        step();
        check_vec("zero_compare_no_ti", cause_out, 32'h0);

        // Timer: enable IM7+IE, Compare=10, then restart Count at 0
        mtc0(CP0_STATUS, 3'd0, 32'h0000_8001);
        check_vec("status_wr", status_out, 32'h0000_8001);
        mtc0(CP0_COMPARE, 3'd0, 32'd10);
        mtc0(CP0_COUNT, 3'd0, 32'd0);
        mfc0_chk("count_loaded", CP0_COUNT, 3'd0, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (int_req !== 1'b0) check_vec("intreq_early", {31'd0, int_req}, 32'd0);
        end
        mfc0_chk("count_at_20", CP0_COUNT, 3'd0, 32'd10);
        check_vec("ti_not_yet", cause_out, 32'h0);
        step();
        check_vec("ti_intreq", {31'd0, int_req}, 32'd1);
        check_vec("ti_cause", cause_out, 32'h4000_8000);
        mtc0(CP0_COMPARE, 3'd0, 32'd50);
        check_vec("ti_clear_intreq", {31'd0, int_req}, 32'd0);
        check_vec("ti_clear_cause", cause_out, 32'h0);
        mfc0_chk("compare_rd", CP0_COMPARE, 3'd0, 32'd50);

        // Exception in a delay slot with BadVAddr capture
        exc_valid = 1'b1; exc_pc = 32'hBFC0_0100; exc_bd = 1'b1; exc_code = EXC_SYS;
        exc_badvaddr = 32'hDEAD_BEEF; exc_badv_we = 1'b1;
        step();
        exc_valid = 1'b0; exc_badv_we = 1'b0;
        check_vec("exc_epc", epc_out, 32'hBFC0_00FC);
        check_vec("exc_cause", cause_out, 32'h8000_0020);
        check_vec("exc_status", status_out, 32'h0000_8003);
        check_vec("exc_intreq_masked", {31'd0, int_req}, 32'd0);
        mfc0_chk("badvaddr_rd", CP0_BADVADDR, 3'd0, 32'hDEAD_BEEF);

        // Exception beats a same-cycle mtc0 EPC
        exc_valid = 1'b1; exc_pc = 32'h0000_0400; exc_bd = 1'b0; exc_code = EXC_ADEL;
        wr_cp0op = CP0OP_MTC0; wr_cs = CP0_EPC; wr_sel = 3'd0; wr_data = 32'h0000_1234;
        step();
        wr_cp0op = 3'b000; exc_valid = 1'b0;
        check_vec("exc_vs_mtc0_epc", epc_out, 32'h0000_0400);
        check_vec("exc2_cause", cause_out, 32'h0000_0010);

        eret_commit = 1'b1;
        step();
        eret_commit = 1'b0;
        check_vec("eret_status", status_out, 32'h0000_8001);
        id_cp0op = CP0OP_ERET;
        #1;
        check_vec("eret_rd", rd_data, 32'h0000_0400);
        id_cp0op = 3'b000;

        // Unimplemented select and read-only BadVAddr
        mtc0(CP0_STATUS, 3'd1, 32'hFFFF_FFFF);
        check_vec("sel1_no_write", status_out, 32'h0000_8001);
        mfc0_chk("sel1_rd", CP0_STATUS, 3'd1, 32'h0);
        mtc0(CP0_BADVADDR, 3'd0, 32'h0);
        mfc0_chk("badvaddr_ro", CP0_BADVADDR, 3'd0, 32'hDEAD_BEEF);

        // Same-cycle read sees the old value
        wr_cp0op = CP0OP_MTC0; wr_cs = CP0_EPC; wr_sel = 3'd0; wr_data = 32'h0000_1234;
        mfc0_chk("epc_old_before_edge", CP0_EPC, 3'd0, 32'h0000_0400);
        step();
        wr_cp0op = 3'b000;
        mfc0_chk("epc_new", CP0_EPC, 3'd0, 32'h0000_1234);

        // Count wraps and the load restarts the tick phase
        mtc0(CP0_COUNT, 3'd0, 32'hFFFF_FFFF);
        mfc0_chk("wrap_load", CP0_COUNT, 3'd0, 32'hFFFF_FFFF);
        step();
        mfc0_chk("wrap_hold", CP0_COUNT, 3'd0, 32'hFFFF_FFFF);
        step();
        mfc0_chk("wrap_zero", CP0_COUNT, 3'd0, 32'h0);

        // hw_int has one cycle of latency into Cause.IP
        hw_int = 6'b100000;
        #1;
        check_vec("hw_latency", {31'd0, int_req}, 32'd0);
        step();
        check_vec("hw_intreq", {31'd0, int_req}, 32'd1);
        check_vec("hw_cause", cause_out, 32'h0000_8010);
        hw_int = 6'd0;
        step();
        check_vec("hw_drop", {31'd0, int_req}, 32'd0);

        // Software IP bits are the only writable Cause bits
        mtc0(CP0_CAUSE, 3'd0, 32'hFFFF_FFFF);
        check_vec("cause_sw_wr", cause_out, 32'h0000_0310);
        check_vec("sw_ip_masked", {31'd0, int_req}, 32'd0);
        mtc0(CP0_STATUS, 3'd0, 32'h0000_0101);
        check_vec("sw_ip_intreq", {31'd0, int_req}, 32'd1);

        // Exception and eret together leave EXL set
        exc_valid = 1'b1; eret_commit = 1'b1; exc_pc = 32'h0000_0080; exc_bd = 1'b0;
        exc_code = EXC_INT;
        step();
        exc_valid = 1'b0; eret_commit = 1'b0;
        check_vec("exc_eret_status", status_out, 32'h0000_0103);
        check_vec("exc_eret_cause", cause_out, 32'h0000_0300);
        check_vec("exc_eret_epc", epc_out, 32'h0000_0080);
        check_vec("rd_idle", rd_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
